// File: rtl/reg_bank_shift_pkg.sv
`default_nettype none
// reg_bank_pkg: flag bit positions, control FSM states and a flag packing helper.
// Revision: 1.0
package reg_bank_pkg;

  localparam int FLAG_S = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [3:0] mk_flags(input logic n, input logic z,
                                          input logic c, input logic s);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_S] = s;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_shift_if.sv
`default_nettype none
// reg_bank_shift_if: write/read/shift bus of the register bank.
// Revision: 1.0
interface reg_bank_shift_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH) + 1;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             shift_start;
  logic [AW-1:0]    shift_addr;
  logic [SW-1:0]    shift_amt;
  logic             shift_arith;
  logic             busy;
  logic             done;
  logic [3:0]       flags;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
           shift_start, shift_addr, shift_amt, shift_arith,
    output rd_data_a, rd_data_b, busy, done, flags
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
           shift_start, shift_addr, shift_amt, shift_arith,
    input  rd_data_a, rd_data_b, busy, done, flags
  );
endinterface
`default_nettype wire

// File: rtl/reg_bank_shift_ctrl.sv
`default_nettype none
// reg_bank_shift_ctrl: shift sequencer -- counter, latched target/mode, busy/done.
// Revision: 1.0
module reg_bank_shift_ctrl
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 2,
  parameter int SW    = 6
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          i_start,
  input  wire logic [AW-1:0] i_addr,
  input  wire logic [SW-1:0] i_amt,
  input  wire logic          i_arith,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_accept,
  output logic               o_zero,
  output logic               o_step,
  output logic               o_last,
  output logic [AW-1:0]      o_addr,
  output logic               o_arith
);

  localparam logic [SW-1:0] c_width = SW'(WIDTH);

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_arith;
  logic          r_done;
  logic [SW-1:0] w_amt_sat;

  assign w_amt_sat = (i_amt > c_width) ? c_width : i_amt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    o_accept = 1'b0;
    o_zero   = 1'b0;
    o_step   = 1'b0;
    o_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          o_accept = 1'b1;
          if (w_amt_sat != '0) w_next = SHIFT;
          else                 o_zero = 1'b1;
        end
      end
      SHIFT: begin
        o_step = 1'b1;
        if (r_cnt == SW'(1)) begin
          o_last = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_arith <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= o_last | o_zero;
      if (o_accept) begin
        r_addr  <= i_addr;
        r_arith <= i_arith;
        r_cnt   <= w_amt_sat;
      end else if (o_step) begin
        r_cnt <= r_cnt - SW'(1);
      end
    end
  end

  assign o_busy  = (r_state == SHIFT);
  assign o_done  = r_done;
  assign o_addr  = r_addr;
  assign o_arith = r_arith;

endmodule
`default_nettype wire

// File: rtl/reg_bank_shift.sv
`default_nettype none
// reg_bank_shift: DEPTH x WIDTH register bank with bit-serial in-place right shift and NZCS flags.
// Revision: 1.0
module reg_bank_shift
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  reg_bank_shift_if.slave bus_if
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            SW      = $clog2(WIDTH) + 1;
  localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [3:0]       r_flags;
  logic             r_acc_s;

  logic             w_busy, w_done, w_accept, w_zero, w_step, w_last, w_arith;
  logic [AW-1:0]    w_tgt_addr;
  logic             w_wr_in, w_rda_in, w_rdb_in, w_tgt_in, w_sa_in;
  logic             w_wr_hit;
  logic [WIDTH-1:0] w_tgt, w_shifted, w_zsrc;
  logic             w_out;

  reg_bank_shift_ctrl #(
    .WIDTH (WIDTH),
    .AW    (AW),
    .SW    (SW)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .i_start  (bus_if.shift_start),
    .i_addr   (bus_if.shift_addr),
    .i_amt    (bus_if.shift_amt),
    .i_arith  (bus_if.shift_arith),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_accept (w_accept),
    .o_zero   (w_zero),
    .o_step   (w_step),
    .o_last   (w_last),
    .o_addr   (w_tgt_addr),
    .o_arith  (w_arith)
  );

  assign w_wr_in  = {1'b0, bus_if.wr_addr}    < c_depth;
  assign w_rda_in = {1'b0, bus_if.rd_addr_a}  < c_depth;
  assign w_rdb_in = {1'b0, bus_if.rd_addr_b}  < c_depth;
  assign w_tgt_in = {1'b0, w_tgt_addr}        < c_depth;
  assign w_sa_in  = {1'b0, bus_if.shift_addr} < c_depth;

  // The register being shifted is locked against writes until the shift completes.
  assign w_wr_hit = bus_if.wr_en && w_wr_in &&
                    !(w_busy && (bus_if.wr_addr == w_tgt_addr));

  assign w_tgt     = w_tgt_in ? r_regs[w_tgt_addr] : '0;
  assign w_out     = w_tgt[0];
  assign w_shifted = {w_arith & w_tgt[WIDTH-1], w_tgt[WIDTH-1:1]};

  // Zero-length shift reports on the value the target holds after this edge's write.
  assign w_zsrc = (w_wr_hit && (bus_if.wr_addr == bus_if.shift_addr)) ? bus_if.wr_data :
                  (w_sa_in ? r_regs[bus_if.shift_addr] : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_step && w_tgt_in && (AW'(i) == w_tgt_addr))
          r_regs[i] <= w_shifted;
        else if (w_wr_hit && (AW'(i) == bus_if.wr_addr))
          r_regs[i] <= bus_if.wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         r_acc_s <= 1'b0;
    else if (w_accept) r_acc_s <= 1'b0;
    else if (w_step)   r_acc_s <= r_acc_s | w_out;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_flags <= '0;
    else if (w_zero)
      r_flags <= mk_flags(w_zsrc[WIDTH-1], w_zsrc == '0, 1'b0, 1'b0);
    else if (w_last)
      r_flags <= mk_flags(w_shifted[WIDTH-1], w_shifted == '0, w_out, r_acc_s | w_out);
    else if (w_wr_hit)
      r_flags <= mk_flags(bus_if.wr_data[WIDTH-1], bus_if.wr_data == '0, 1'b0, 1'b0);
  end

  assign bus_if.rd_data_a = w_rda_in ? r_regs[bus_if.rd_addr_a] : '0;
  assign bus_if.rd_data_b = w_rdb_in ? r_regs[bus_if.rd_addr_b] : '0;
  assign bus_if.busy      = w_busy;
  assign bus_if.done      = w_done;
  assign bus_if.flags     = r_flags;

endmodule
`default_nettype wire
